usb_dir_sched: RTL
==================

Name: usb_dir_sched

Overview:
- Direction scheduler for the FX3 slave-FIFO stream engine.
- Arbitrates the shared GPIF bus between RX (host->FPGA, DA sample path) and TX (FPGA->host, readback path).
- Drives the engine's data_dir select and a burst enable, and counts beats per grant.
- Inserts address turnaround gaps and alternates direction fairly when both sides are pending.

Parameters:
- BURST_MAX, 1024, maximum beats per grant before re-arbitration; must be >= 2.
- TURN_CYC, 4, idle cycles after a data_dir change before xfer_en may assert (FX3 address settle); must be >= 1.
- Local constant CNT_W = $clog2(BURST_MAX+1); derived, not overridable.

Ports:
- clk  in  1  system clock, same clock as the stream engine.
- rst_n  in  1  asynchronous active-low reset.
- rx_room  in  1  downstream DA FIFO can accept at least BURST_MAX words.
- tx_pend  in  1  upstream readback FIFO holds at least 1 word.
- FLAGA  in  1  FX3 flag for the currently addressed thread; 1 = data available (RX) or space available (TX).
- beat  in  1  stream engine performed one SLRD/SLWR strobe this cycle.
- data_dir  out  1  0 = RX (A1A0=11), 1 = TX (A1A0=00).
- xfer_en  out  1  engine may strobe this cycle.
- burst_cnt  out  CNT_W  beats completed in the current grant.
- sched_state  out  3  current state encoding.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset values: state IDLE, data_dir=0, xfer_en=0, burst_cnt=0, proto_err=0, internal last_dir=1 (TX). Reset is asynchronous; asserting it mid-burst drops xfer_en immediately and returns all outputs to reset values.
- State encoding: IDLE=0, TURN=1, RX=2, TX=3. Values 4-7 are illegal and go to IDLE on the next edge.
- IDLE:
  - xfer_en=0, burst_cnt cleared.
  - Candidates: rx_room for RX, tx_pend for TX.
  - If both are pending, choose the opposite of last_dir. If one is pending, choose it. If neither, stay in IDLE.
  - If the chosen direction equals data_dir, go directly to RX or TX.
  - Otherwise load data_dir with the new direction, load the turn counter with TURN_CYC-1, and go to TURN.
- TURN:
  - xfer_en=0; counter decrements each cycle.
  - At 0, go to the state matching data_dir. Total gap is exactly TURN_CYC cycles from the data_dir change to the first xfer_en=1.
  - Request inputs are not re-sampled during TURN.
- RX / TX:
  - xfer_en=1 (registered, asserts the cycle the state is entered); burst_cnt increments on each beat.
  - Terminal conditions, evaluated each cycle:
    - beat with burst_cnt==BURST_MAX-1.
    - FLAGA==0 (FX3 empty for RX, full for TX).
    - rx_room==0 in RX, or tx_pend==0 in TX.
  - On a terminal condition: go to IDLE, set last_dir=data_dir; xfer_en is 0 the next cycle.
  - A beat coincident with a terminal condition is counted. burst_cnt saturates at BURST_MAX and never wraps.
  - If a terminal condition holds on the first cycle, the grant ends with 0 beats. This is legal, not an error.
- IDLE -> same direction re-grant costs exactly 1 idle cycle; no turnaround is inserted.
- proto_err is set when beat==1 while xfer_en==0, and stays set until reset.

Optional Feature:
- Macro: USB_SCHED_PKTEND_EN.
- When defined:
  - Adds output pktend (1 bit): a 1-cycle pulse in the cycle after a TX grant ends with 0 < burst_cnt < BURST_MAX.
  - The FX3 PKTEND is thereby issued for short packets.
  - No pulse for full bursts or zero-beat grants.
  - The following IDLE cycle is extended by 1 so that pktend never overlaps a TURN start.
- When undefined: the port does not exist and timing is as above.

Decomposition:
- Package usb_sched_pkg holds:
  - state encoding constants (IDLE/TURN/RX/TX);
  - DIR_RX=1'b0 and DIR_TX=1'b1;
  - the A1A0 codes for each direction (2'b11, 2'b00), shared with the stream engine.
- Single module; no sub-module is warranted. The turn counter and burst counter are inline.

Test Plan:
- Reset, then rx_room=1, tx_pend=0, FLAGA=1, beat every xfer_en cycle -> RX grant with no TURN (data_dir already 0); exactly 1024 beats, then 1 IDLE cycle, then a re-grant.
- Both pending from IDLE with last_dir=TX -> RX grant first. After it ends -> data_dir=1, then 4 cycles with xfer_en=0, then TX grant. Pattern alternates RX/TX.
- TX grant, FLAGA drops after 37 beats -> xfer_en=0 next cycle, burst_cnt=37, state IDLE. With USB_SCHED_PKTEND_EN defined, one pktend pulse.
- beat asserted during a TURN cycle -> proto_err=1 and stays 1; scheduling is unaffected.
- rst_n pulsed low mid-TX burst at beat 500 -> xfer_en, data_dir, burst_cnt and state read 0 immediately, asynchronously.
- rx_room=1 but FLAGA=0 on the RX entry cycle -> zero-beat grant; back to IDLE after 1 cycle; proto_err stays 0.

Source files
------------

// File: rtl/usb_sched_pkg.sv
// Shared constants for the FX3 GPIF direction scheduler and the stream engine:
// scheduler state encoding, direction codes and the A1A0 thread address per direction.
package usb_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TURN = 3'd1,
    ST_RX   = 3'd2,
    ST_TX   = 3'd3
  } sched_state_e;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  localparam logic [1:0] A1A0_RX = 2'b11;
  localparam logic [1:0] A1A0_TX = 2'b00;

  function automatic logic [1:0] dir_to_a1a0(input logic dir);
    return (dir == DIR_TX) ? A1A0_TX : A1A0_RX;
  endfunction

endpackage

// File: rtl/usb_dir_sched.sv
// GPIF bus direction scheduler: fair RX/TX arbitration, address turnaround and per-grant beat count.
// Optional short-packet PKTEND pulse is built when USB_SCHED_PKTEND_EN is defined.
module usb_dir_sched
  import usb_sched_pkg::*;
#(
  parameter  int BURST_MAX = 1024,
  parameter  int TURN_CYC  = 4,
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_room,
  input  logic             tx_pend,
  input  logic             FLAGA,
  input  logic             beat,
  output logic             data_dir,
  output logic             xfer_en,
  output logic [CNT_W-1:0] burst_cnt,
  output logic [2:0]       sched_state,
`ifdef USB_SCHED_PKTEND_EN
  output logic             pktend,
`endif
  output logic             proto_err
);

  localparam int TURN_W = $clog2(TURN_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BURST_MAX);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);

  sched_state_e      state_r, state_s;
  logic              data_dir_r, data_dir_s;
  logic              last_dir_r, last_dir_s;
  logic              xfer_en_r, xfer_en_s;
  logic [CNT_W-1:0]  burst_cnt_r, burst_cnt_s;
  logic [TURN_W-1:0] turn_cnt_r, turn_cnt_s;
  logic              proto_err_r, proto_err_s;
  logic              req_s, pick_s, term_s, hold_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  assign req_s     = rx_room | tx_pend;
  assign pick_s    = (rx_room & tx_pend) ? ~last_dir_r : tx_pend;
  assign cnt_inc_s = (beat && (burst_cnt_r != CNT_FULL)) ? burst_cnt_r + CNT_W'(1'b1) : burst_cnt_r;
  assign term_s    = (beat && (burst_cnt_r == CNT_LAST)) || !FLAGA ||
                     ((state_r == ST_RX) ? !rx_room : !tx_pend);

`ifdef USB_SCHED_PKTEND_EN
  logic pkt_r, pkt_s;

  // Short TX packet: grant ended with some but not all beats of a burst.
  assign pkt_s  = (state_r == ST_TX) && term_s &&
                  (cnt_inc_s != {CNT_W{1'b0}}) && (cnt_inc_s != CNT_FULL);
  assign hold_s = pkt_r;
  assign pktend = pkt_r;

  // PKTEND pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_r <= 1'b0;
    end else begin
      pkt_r <= pkt_s;
    end
  end
`else
  assign hold_s = 1'b0;
`endif

  // Next-state, arbitration and counter update.
  always_comb begin
    state_s     = state_r;
    data_dir_s  = data_dir_r;
    last_dir_s  = last_dir_r;
    xfer_en_s   = 1'b0;
    burst_cnt_s = burst_cnt_r;
    turn_cnt_s  = turn_cnt_r;
    proto_err_s = proto_err_r | (beat & ~xfer_en_r);
    case (state_r)
      ST_IDLE: begin
        burst_cnt_s = {CNT_W{1'b0}};
        if (hold_s) begin
          state_s = ST_IDLE;
        end else if (req_s) begin
          if (pick_s == data_dir_r) begin
            state_s   = (pick_s == DIR_TX) ? ST_TX : ST_RX;
            xfer_en_s = 1'b1;
          end else begin
            data_dir_s = pick_s;
            turn_cnt_s = TURN_LOAD;
            state_s    = ST_TURN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TURN: begin
        burst_cnt_s = {CNT_W{1'b0}};
        if (turn_cnt_r == {TURN_W{1'b0}}) begin
          state_s   = (data_dir_r == DIR_TX) ? ST_TX : ST_RX;
          xfer_en_s = 1'b1;
        end else begin
          turn_cnt_s = turn_cnt_r - TURN_W'(1'b1);
        end
      end
      ST_RX, ST_TX: begin
        // A beat on the terminating cycle still counts toward the grant.
        burst_cnt_s = cnt_inc_s;
        if (term_s) begin
          state_s    = ST_IDLE;
          last_dir_s = (state_r == ST_TX) ? DIR_TX : DIR_RX;
        end else begin
          xfer_en_s = 1'b1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        burst_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      data_dir_r  <= DIR_RX;
      last_dir_r  <= DIR_TX;
      xfer_en_r   <= 1'b0;
      burst_cnt_r <= {CNT_W{1'b0}};
      turn_cnt_r  <= {TURN_W{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_dir_r  <= data_dir_s;
      last_dir_r  <= last_dir_s;
      xfer_en_r   <= xfer_en_s;
      burst_cnt_r <= burst_cnt_s;
      turn_cnt_r  <= turn_cnt_s;
      proto_err_r <= proto_err_s;
    end
  end

  assign data_dir    = data_dir_r;
  assign xfer_en     = xfer_en_r;
  assign burst_cnt   = burst_cnt_r;
  assign sched_state = state_r;
  assign proto_err   = proto_err_r;

endmodule
